muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage. It replaces the fixed 32-bit divider-plus-multiplier pair with one engine behind a single start/ready handshake. It supports signed and unsigned MUL and DIV at any even WIDTH, annul (flush) of an in-flight operation, and explicit divide-by-zero reporting. EX holds its stall request while `busy_o` is high, then writes `result_o` into HI/LO on the `ready_o` cycle.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_unit_div_step.sv | 20 ++
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for muldiv_unit.
// Build option MULDIV_FAST_MUL_EN (see muldiv_unit) selects the single-cycle multiplier.
package muldiv_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } md_state_t;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and subtract the
// divisor if it fits, producing the new partial remainder and quotient bit.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shift;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_divisor});
  // The true difference is below the divisor, so modulo-2^WIDTH subtraction is exact.
  assign o_rem   = o_q ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine with start/ready handshake and annul.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a one-cycle multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int unsigned     CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  md_state_t          r_state;
  logic [CntW-1:0]    r_cnt;
  logic               r_is_div;
  logic               r_sgn_a;
  logic               r_sgn_b;
  logic               r_busy;
  logic               r_ready;
  logic               r_div0;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_work;
  logic [2*WIDTH-1:0] r_result;

  logic               w_is_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_mul_init;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_div_q;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_fixed;

  assign w_is_div = md_is_div(op_i);
  assign w_neg_a  = md_is_signed(op_i) & opdata1_i[WIDTH-1];
  assign w_neg_b  = md_is_signed(op_i) & opdata2_i[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -opdata1_i : opdata1_i;
  assign w_abs_b  = w_neg_b ? -opdata2_i : opdata2_i;

`ifdef MULDIV_FAST_MUL_EN
  assign w_mul_init = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`else
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  // Working register is {partial product, multiplier}; r_opb holds the multiplicand.
  assign w_mul_init = {{WIDTH{1'b0}}, w_abs_b};
  assign w_mul_sum  = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_work[WIDTH-1:1]};
`endif

  // Working register is {partial remainder, remaining dividend / quotient bits}.
  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_work[2*WIDTH-1:WIDTH]),
    .i_bit    (r_work[WIDTH-1]),
    .i_divisor(r_opb),
    .o_rem    (w_div_rem),
    .o_q      (w_div_q)
  );

  assign w_div_next = {w_div_rem, r_work[WIDTH-2:0], w_div_q};
  assign w_quot     = r_work[WIDTH-1:0];
  assign w_rem      = r_work[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fixed = r_work;
    if (r_is_div) begin
      w_fixed[WIDTH-1:0]       = (r_sgn_a ^ r_sgn_b) ? -w_quot : w_quot;
      w_fixed[2*WIDTH-1:WIDTH] = r_sgn_a ? -w_rem : w_rem;
    end else if (r_sgn_a ^ r_sgn_b) begin
      w_fixed = -r_work;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_sgn_a    <= 1'b0;
      r_sgn_b    <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b0;
      r_div0     <= 1'b0;
      r_dividend <= '0;
      r_opb      <= '0;
      r_work     <= '0;
      r_result   <= '0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          if (start_i && !annul_i) begin
            r_state    <= w_is_div ? DIV : MUL;
            r_is_div   <= w_is_div;
            r_sgn_a    <= w_neg_a;
            r_sgn_b    <= w_neg_b;
            r_dividend <= opdata1_i;
            r_opb      <= w_is_div ? w_abs_b : w_abs_a;
            r_work     <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : w_mul_init;
            r_cnt      <= '0;
            r_div0     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        MUL: begin
          if (annul_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
          end else begin
`else
          end else if (r_cnt != LastCnt) begin
            r_work <= w_mul_next;
            r_cnt  <= r_cnt + 1'b1;
          end else begin
`endif
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_result <= w_fixed;
          end
        end
        DIV: begin
          if (annul_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_opb == '0) begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_div0   <= 1'b1;
            r_result <= {r_dividend, {WIDTH{1'b1}}};
          end else if (r_cnt != LastCnt) begin
            r_work <= w_div_next;
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            r_state  <= DONE;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
            r_result <= w_fixed;
          end
        end
      endcase
    end
  end

  assign busy_o        = r_busy;
  assign ready_o       = r_ready;
  assign result_o      = r_result;
  assign div_by_zero_o = r_div0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH = 32: directed cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;
  logic        div_by_zero_o;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(
    .WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .op_i         (op_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .busy_o       (busy_o),
    .ready_o      (ready_o),
    .result_o     (result_o),
    .div_by_zero_o(div_by_zero_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic for one operation.
  function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    case (op)
      2'b00: res = {32'h0, a} * {32'h0, b};
      2'b01: res = 64'(sa * sb);
      default: begin
        if (b == 32'h0) begin
          dz  = 1'b1;
          res = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          res = {a % b, a / b};
        end else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
    if (op[1] == 1'b0) return MulLat;
    if (b == 32'h0) return 2;
    return DivLat;
  endfunction

  // Model state: age counts cycles since acceptance (acceptance cycle = 0).
  logic        m_active = 1'b0;
  int          m_age    = 0;
  int          m_lat    = 0;
  logic [63:0] m_pres   = '0;
  logic        m_pdz    = 1'b0;
  logic [63:0] m_res    = '0;
  logic        m_div0   = 1'b0;
  logic        m_busy_c;
  logic        m_done_c;

  function automatic logic exp_busy();
    return m_active && (m_age >= 1) && (m_age < m_lat);
  endfunction

  function automatic logic exp_ready();
    return m_active && (m_age == m_lat);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_age    = 0;
      m_res    = '0;
      m_div0   = 1'b0;
    end else begin
      m_busy_c = exp_busy();
      m_done_c = exp_ready();
      if (m_busy_c && annul_i) begin
        m_active = 1'b0;
      end else if (m_busy_c && (m_age + 1 == m_lat)) begin
        m_res  = m_pres;
        m_div0 = m_pdz;
      end
      if (!m_busy_c && start_i && !annul_i) begin
        m_active = 1'b1;
        m_age    = 1;
        m_div0   = 1'b0;
        m_pres   = ref_calc(op_i, opdata1_i, opdata2_i, m_pdz);
        m_lat    = ref_lat(op_i, opdata2_i);
      end else if (m_done_c) begin
        m_active = 1'b0;
      end else if (m_active) begin
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    check("busy_o", 64'(busy_o), 64'(exp_busy()));
    check("ready_o", 64'(ready_o), 64'(exp_ready()));
    check("result_o", result_o, m_res);
    check("div_by_zero_o", 64'(div_by_zero_o), 64'(m_div0));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [63:0] exp_res,
                        input logic exp_dz);
    int          n;
    int          nbusy;
    logic [63:0] mres;
    logic        mdz;
    mres = ref_calc(op, a, b, mdz);
    check({nm, "_model"}, mres, exp_res);
    check({nm, "_model_dz"}, 64'(mdz), 64'(exp_dz));
    start_i   = 1'b1;
    op_i      = op;
    opdata1_i = a;
    opdata2_i = b;
    annul_i   = 1'b0;
    next_cycle();
    start_i   = 1'b0;
    op_i      = 2'($urandom);
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    n     = 1;
    nbusy = 0;
    while (!ready_o && n < 100) begin
      if (busy_o) nbusy++;
      next_cycle();
      n++;
    end
    check({nm, "_latency"}, 64'(n), 64'(lat));
    check({nm, "_busy_cycles"}, 64'(nbusy), 64'(lat - 1));
    check({nm, "_result"}, result_o, exp_res);
    check({nm, "_dz"}, 64'(div_by_zero_o), 64'(exp_dz));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"}, 64'(busy_o), 64'h0);
    check({nm, "_ready"}, 64'(ready_o), 64'h0);
    check({nm, "_result"}, result_o, 64'h0);
    check({nm, "_dz"}, 64'(div_by_zero_o), 64'h0);
  endtask

  initial begin
    rst       = 1'b0;
    start_i   = 1'b0;
    op_i      = 2'b00;
    opdata1_i = '0;
    opdata2_i = '0;
    annul_i   = 1'b0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, DivLat, {32'h2, 32'hE}, 1'b0);
    next_cycle();
    run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, DivLat, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
           1'b0);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, DivLat, {32'h0, 32'h8000_0000},
           1'b0);
    next_cycle();
    run_op("mult", 2'b01, 32'hFFFF_FFFF, 32'd2, MulLat, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("multu", 2'b00, 32'hFFFF_FFFF, 32'd2, MulLat, 64'h0000_0001_FFFF_FFFE, 1'b0);
    next_cycle();
    run_op("div_by0", 2'b11, 32'd5, 32'd0, 2, {32'h5, 32'hFFFF_FFFF}, 1'b1);
    run_op("divu_9_3", 2'b10, 32'd9, 32'd3, DivLat, {32'h0, 32'h3}, 1'b0);
    next_cycle();

    // Annul a DIV in cycle 10, then start a new op in cycle 11.
    start_i   = 1'b1;
    op_i      = 2'b11;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    next_cycle();
    start_i = 1'b0;
    repeat (9) next_cycle();
    annul_i = 1'b1;
    next_cycle();
    annul_i = 1'b0;
    check("annul_busy", 64'(busy_o), 64'h0);
    check("annul_ready", 64'(ready_o), 64'h0);
    check("annul_result", result_o, 64'h3);
    run_op("after_annul", 2'b00, 32'd3, 32'd5, MulLat, 64'd15, 1'b0);
    next_cycle();

    // Asynchronous reset in cycle 15 of a DIV.
    start_i   = 1'b1;
    op_i      = 2'b10;
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    next_cycle();
    start_i = 1'b0;
    repeat (14) next_cycle();
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    #1 rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 3000; i++) begin
      start_i   = ($urandom_range(0, 99) < 30);
      annul_i   = ($urandom_range(0, 99) < 1);
      op_i      = 2'($urandom);
      opdata1_i = pick_operand();
      opdata2_i = pick_operand();
      next_cycle();
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (40) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
